// File: rtl/pio_pkg.sv
// Shared register map and constant helpers for the pushbutton input PIO.
// Pulled in by the debounce cell and the top level.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Smallest r with 2**r >= value; used to size the debounce counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input line: two-flop synchroniser followed by a hold-time debounce filter.
// Latency 2 + DEBOUNCE_CYCLES clocks from din_i to level_o; no backpressure.
module pio_debounce
    import pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic level_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign level_o = sync2_q;
    end else begin : g_count
        localparam int            CW   = clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          level_q;
        logic          level_d;

        // Counter only runs while the synchronised input disagrees with the
        // accepted level; it tops out at LAST and clears, so it never wraps.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            if (sync2_q != level_q) begin
                if (cnt_q == LAST) begin
                    level_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q   <= '0;
                level_q <= IDLE_LEVEL;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign level_o = level_q;
    end

endmodule

// File: rtl/pio_button_in.sv
// Avalon-MM input PIO: debounced level, per-bit edge capture with W1C clear, masked irq.
// Read data is combinational (zero wait states); irq is registered one clock after capture/mask.
module pio_button_in
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_d1_q;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] clr_bits;
    logic             irq_q;
    logic             irq_d;
    logic             wr_en;
    logic             unused_ok;

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .din_i   (in_port[i]),
            .level_o (level[i])
        );
    end

    // Edge = previous level idle, current level active.
    assign edge_pulse = ~(level_d1_q ^ IDLE_VEC) & (level ^ IDLE_VEC);

    always_comb begin
        wr_en  = chipselect && !write_n;
        mask_d = mask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        clr_bits = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clr_bits = writedata[WIDTH-1:0];
        end
        // OR-ing the new edge after the clear makes a coincident set win.
        edgecap_d = (edgecap_q & ~clr_bits) | edge_pulse;
        irq_d     = |(edgecap_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_d1_q <= IDLE_VEC;
            mask_q     <= '0;
            edgecap_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            level_d1_q <= level;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_DATA:    readdata = 32'(level);
            ADDR_RSVD:    readdata = '0;
            ADDR_IRQMASK: readdata = 32'(mask_q);
            ADDR_EDGECAP: readdata = 32'(edgecap_q);
            default:      readdata = '0;
        endcase
    end

    assign irq = irq_q;

    // read_n has no side effects and upper writedata bits may be beyond WIDTH.
    assign unused_ok = &{1'b0, read_n, writedata};

endmodule

// File: tb/tb_pio_button_in.sv
// Scoreboard bench for pio_button_in with WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1.
module tb_pio_button_in;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_checks;
    int       n_errors;

    pio_button_in #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .IDLE_LEVEL      (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected value is queued at stimulus time, then popped and compared on sampling.
    task automatic expect_reg(input logic [1:0] addr, input string tag, input logic [31:0] exp);
        sb_item_t it;
        sb_q.push_back('{tag: tag, exp: exp});
        address    = addr;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1;
        it = sb_q.pop_front();
        check_eq(it.tag, readdata, it.exp);
        read_n = 1'b1;
    endtask

    task automatic expect_irq(input string tag, input logic exp);
        sb_item_t it;
        sb_q.push_back('{tag: tag, exp: {31'd0, exp}});
        #1;
        it = sb_q.pop_front();
        check_eq(it.tag, {31'd0, irq}, it.exp);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        step(2);
        reset = 1'b0;

        // Reset state
        expect_reg(2'd0, "rst_data", 32'h0000_000F);
        expect_irq("rst_irq", 1'b0);
        expect_reg(2'd1, "rst_rsvd", 32'h0);
        expect_reg(2'd2, "rst_mask", 32'h0);
        expect_reg(2'd3, "rst_edgecap", 32'h0);

        // Press bit 2: accepted exactly 6 clocks later
        in_port[2] = 1'b0;
        step(5);
        expect_reg(2'd0, "lat_data_5", 32'hF);
        step(1);
        expect_reg(2'd0, "lat_data_6", 32'hB);
        expect_reg(2'd3, "lat_cap_6", 32'h0);
        step(1);
        expect_reg(2'd3, "lat_cap_7", 32'h4);
        step(1);
        expect_irq("masked_irq", 1'b0);

        // Clear, release, check release makes no edge
        bus_write(2'd3, 32'h4);
        in_port[2] = 1'b1;
        step(8);
        expect_reg(2'd0, "rel_data", 32'hF);
        expect_reg(2'd3, "rel_cap", 32'h0);

        // Unmasked press raises irq one clock after capture
        bus_write(2'd2, 32'h4);
        expect_reg(2'd2, "mask_rd", 32'h4);
        expect_irq("mask_irq0", 1'b0);
        in_port[2] = 1'b0;
        step(7);
        expect_reg(2'd3, "irq_cap", 32'h4);
        expect_irq("irq_pre", 1'b0);
        step(1);
        expect_irq("irq_set", 1'b1);
        bus_write(2'd3, 32'h4);
        expect_reg(2'd3, "w1c_cap", 32'h0);
        step(1);
        expect_irq("irq_clr", 1'b0);
        in_port[2] = 1'b1;
        step(8);

        // 3-cycle glitch rejected
        in_port[0] = 1'b0;
        step(3);
        in_port[0] = 1'b1;
        step(10);
        expect_reg(2'd0, "glitch_data", 32'hF);
        expect_reg(2'd3, "glitch_cap", 32'h0);

        // 4-cycle hold accepted
        in_port[0] = 1'b0;
        step(4);
        in_port[0] = 1'b1;
        step(2);
        expect_reg(2'd0, "hold_data", 32'hE);
        step(10);
        expect_reg(2'd0, "hold_back", 32'hF);
        expect_reg(2'd3, "hold_cap", 32'h1);
        expect_irq("hold_irq_masked", 1'b0);
        bus_write(2'd3, 32'h1);
        expect_reg(2'd3, "hold_clr", 32'h0);

        // Edge set coincident with W1C on the same bit: set wins
        in_port[1] = 1'b0;
        step(6);
        bus_write(2'd3, 32'h2);
        expect_reg(2'd3, "set_wins", 32'h2);
        bus_write(2'd3, 32'h0);
        expect_reg(2'd3, "w0_nochange", 32'h2);

        // Pending irq then reset
        bus_write(2'd2, 32'h6);
        step(1);
        expect_irq("pend_irq", 1'b1);
        reset   = 1'b1;
        in_port = 4'hF;
        step(1);
        reset = 1'b0;
        expect_irq("rst2_irq", 1'b0);
        expect_reg(2'd3, "rst2_cap", 32'h0);
        expect_reg(2'd0, "rst2_data", 32'hF);
        expect_reg(2'd2, "rst2_mask", 32'h0);
        step(10);
        expect_reg(2'd3, "rst2_nocap", 32'h0);
        expect_irq("rst2_irq_late", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
